chan_link_fifo: RTL
===================

# chan_link_fifo

Parametrised N-channel successor to the single-bit drive/observe link. Every channel carries a WIDTH-bit word from the driving side to the observing side through its own DEPTH-entry FIFO with valid/ready handshakes on both sides. A synchronous flush input clears all channels, and per-channel occupancy is reported. The block sits between a testbench-facing producer and a DUT-side consumer, or between two sub-hierarchies joined by a link interface.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of independent channels (≥1)
- DEPTH, 2, FIFO entries per channel (power of two, ≥2)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all channels
- in_valid  input  CHANNELS  per-channel producer valid
- in_ready  output  CHANNELS  per-channel FIFO can accept
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- out_valid  output  CHANNELS  per-channel head word present
- out_ready  input  CHANNELS  per-channel consumer ready
- out_data  output  CHANNELS*WIDTH  head word of channel i, same packing
- level  output  CHANNELS*LW  occupancy of channel i at [i*LW +: LW], LW = $clog2(DEPTH+1)

## Operation
- Channels are fully independent. The only shared signal is flush.
- Push on channel i when in_valid[i] && in_ready[i] at a clock edge. Pop when out_valid[i] && out_ready[i].
- in_ready[i] = (level[i] != DEPTH) && !flush. It does not depend on out_ready, so a full FIFO refuses a push even while popping in the same cycle.
- out_valid[i] = (level[i] != 0). out_data[i] = entry at the read pointer, driven from storage with no combinational path from in_data.
- Push and pop in the same cycle with 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is kept as an explicit counter, not derived from pointer difference.
- Pop while empty cannot occur (out_valid low). Push while full cannot occur (in_ready low). in_valid/out_ready asserted in those cases are ignored with no state change.
- Producer rule: once in_valid[i] is asserted, in_data[i] is held until accepted. The block does not check this.
- flush high at an edge: all levels and pointers go to 0 and no push or pop takes effect that cycle. out_valid may be high during the flush cycle; a consumer pop in that cycle is discarded.
- Storage contents are not cleared by flush. out_data is don't-care while out_valid is low.

## Timing
- Reset (rst_n low, asynchronous): level = 0, pointers = 0, out_valid = 0, out_data = 0 (storage reset to 0), in_ready = all-ones unless flush is high.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N; it can be popped at edge N+1 at the earliest.
- Throughput: one word per cycle per channel in steady state once level ≥ 1.
- rst_n deasserted mid-stream: all in-flight words are lost. The first push after release is accepted at the first edge with rst_n high.
- rst_n asserted while flush is high: reset dominates. in_ready stays low only while flush is high.

## Structure
- Shared package chan_link_pkg: function for level width (clog2(DEPTH+1)) and a localparam default WIDTH/DEPTH pair used by benches.
- One sub-module, chan_link_fifo_ch: single-channel FIFO (storage, pointers, level, handshakes), instantiated CHANNELS times in a generate loop.
- Optional wrapper interface link_if with modports drv (outputs valid/data, input ready) and obs (mirror), for hierarchical connection. The core block uses flat ports.

## Test plan
- Reset then idle: after rst_n rises, out_valid = 0, level = 0, in_ready = 4'b1111, out_data = 0 on all channels.
- Single word, ch0: push 8'hA5 at edge N → out_valid[0] = 1 and out_data[0] = A5 after N; pop at N+1 → level[0] = 0; other channels untouched.
- Fill and stall (DEPTH=2), ch2: push 11, 22 with out_ready = 0 → level = 2, in_ready[2] = 0; a third push of 33 is ignored; pop both → 11 then 22, order preserved.
- Full with simultaneous pop: ch1 full, in_valid = out_ready = 1 → pop occurs, push refused, level 2→1; next cycle push accepted, level back to 2.
- Wrap and streaming: continuous push/pop of 0..15 on all channels at one per cycle → outputs 0..15 in order, level constant at 1, pointers wrap cleanly.
- Flush and async reset: flush with ch3 holding 2 words and in_valid high → level = 0 next cycle, pushed word dropped. Then assert rst_n mid-stream between edges → outputs reset immediately without a clock edge.

Source files
------------

// File: rtl/chan_link_pkg.sv
// Shared definitions for the multi-channel link FIFO: level width helper and
// the default geometry used by benches.
package chan_link_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/chan_link_fifo_ch.sv
// Single-channel FIFO: storage, wrapping pointers, explicit level counter and
// valid/ready handshakes on both sides.
module chan_link_fifo_ch
    import chan_link_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LW    = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_nxt_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;

    assign in_ready_s  = (level_r != LW'(DEPTH)) && !flush;
    assign out_valid_s = (level_r != LW'(0));
    assign push_s      = in_valid && in_ready_s;
    // A pop presented during flush is discarded.
    assign pop_s       = out_valid_s && out_ready && !flush;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (!push_s && pop_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Pointer and level registers; flush clears them but not storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= LW'(0);
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_nxt_s;
        end
    end

    // Word storage, zeroed only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: rtl/chan_link_fifo.sv
// N independent link channels, each with its own FIFO; flush is the only
// signal shared between channels.
module chan_link_fifo
    import chan_link_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic [CHANNELS-1:0]                    in_valid,
    output logic [CHANNELS-1:0]                    in_ready,
    input  logic [CHANNELS*WIDTH-1:0]              in_data,
    output logic [CHANNELS-1:0]                    out_valid,
    input  logic [CHANNELS-1:0]                    out_ready,
    output logic [CHANNELS*WIDTH-1:0]              out_data,
    output logic [CHANNELS*level_width(DEPTH)-1:0] level
);

    localparam int LW = level_width(DEPTH);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        chan_link_fifo_ch #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g*WIDTH +: WIDTH]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g*WIDTH +: WIDTH]),
            .level     (level[g*LW +: LW])
        );
    end

endmodule
